// File: rtl/clk_div_cascade.sv
// Two-stage cascaded divider: stage A divides the board clock, stage B divides stage A.
// Optional tick_b event counter (sec_cnt) is built when CLKDIV_SECCNT_EN is defined.
module clk_div_cascade #(
   parameter int DIV_A    = 50000,
   parameter int DIV_B    = 1000,
   parameter int FAST_DIV = 100,
   parameter int SEC_W    = 17
) (
   input  logic             in_50MHz,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             fast,
   output logic             tick_a,
   output logic             tick_b,
   output logic             sq_a,
`ifdef CLKDIV_SECCNT_EN
   output logic             sq_b,
   output logic [SEC_W-1:0] sec_cnt
`else
   output logic             sq_b
`endif
);

   localparam int CNT_A_W = $clog2(DIV_A);
   localparam int CNT_B_W = $clog2(DIV_B);

   // Stage B limits are stored as (limit-1) and limit/2 so a power-of-two DIV_B still fits CNT_B_W.
   localparam logic [CNT_A_W-1:0] A_LAST   = CNT_A_W'(DIV_A - 1);
   localparam logic [CNT_A_W-1:0] A_HALF   = CNT_A_W'(DIV_A / 2);
   localparam logic [CNT_B_W-1:0] B_LAST_N = CNT_B_W'(DIV_B - 1);
   localparam logic [CNT_B_W-1:0] B_LAST_F = CNT_B_W'(FAST_DIV - 1);
   localparam logic [CNT_B_W-1:0] B_HALF_N = CNT_B_W'(DIV_B / 2);
   localparam logic [CNT_B_W-1:0] B_HALF_F = CNT_B_W'(FAST_DIV / 2);

   if (DIV_A < 2 || DIV_A % 2 != 0 || DIV_B < 2 || DIV_B % 2 != 0 ||
       FAST_DIV < 2 || FAST_DIV % 2 != 0 || FAST_DIV > DIV_B || SEC_W < 1) begin : g_param_chk
      $error("clk_div_cascade: illegal parameter combination");
   end

   logic [CNT_A_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_B_W-1:0] cnt_b_q, cnt_b_d;
   logic               tick_a_q, tick_a_d;
   logic               tick_b_q, tick_b_d;
   logic               sq_a_q, sq_a_d;
   logic               sq_b_q, sq_b_d;
   logic               wrap_a;
   logic [CNT_B_W-1:0] last_b;
   logic [CNT_B_W-1:0] half_b;

   assign wrap_a = en & (cnt_a_q == A_LAST);
   assign last_b = fast ? B_LAST_F : B_LAST_N;
   assign half_b = fast ? B_HALF_F : B_HALF_N;

   always_comb begin
      // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
      cnt_a_d  = cnt_a_q;
      cnt_b_d  = cnt_b_q;
      tick_a_d = 1'b0;
      tick_b_d = 1'b0;
      sq_a_d   = sq_a_q;
      sq_b_d   = sq_b_q;
      if (sync_clr) begin
         cnt_a_d = '0;
         cnt_b_d = '0;
         sq_a_d  = 1'b0;
         sq_b_d  = 1'b0;
      end else if (en) begin
         cnt_a_d  = wrap_a ? '0 : cnt_a_q + 1'b1;
         tick_a_d = wrap_a;
         if (wrap_a) begin
            if (cnt_b_q >= last_b) begin
               cnt_b_d  = '0;
               tick_b_d = 1'b1;
            end else begin
               cnt_b_d = cnt_b_q + 1'b1;
            end
         end
         // Squares decode the next counter state, so they never drift from the counters.
         sq_a_d = (cnt_a_d >= A_HALF);
         sq_b_d = (cnt_b_d >= half_b);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge in_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         tick_a_q <= 1'b0;
         tick_b_q <= 1'b0;
         sq_a_q   <= 1'b0;
         sq_b_q   <= 1'b0;
      end else begin
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
         tick_a_q <= tick_a_d;
         tick_b_q <= tick_b_d;
         sq_a_q   <= sq_a_d;
         sq_b_q   <= sq_b_d;
      end
   end

   assign tick_a = tick_a_q;
   assign tick_b = tick_b_q;
   assign sq_a   = sq_a_q;
   assign sq_b   = sq_b_q;

`ifdef CLKDIV_SECCNT_EN
   logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;

   always_comb begin
      sec_cnt_d = sec_cnt_q;
      if (sync_clr)
         sec_cnt_d = '0;
      else if (tick_b_d)
         sec_cnt_d = sec_cnt_q + 1'b1;
   end

   always_ff @(posedge in_50MHz or negedge rst_n) begin
      if (!rst_n)
         sec_cnt_q <= '0;
      else
         sec_cnt_q <= sec_cnt_d;
   end

   assign sec_cnt = sec_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_cascade.sv
// Directed bench for clk_div_cascade with DIV_A=4, DIV_B=6, FAST_DIV=2 (SEC_W=3 when
// CLKDIV_SECCNT_EN is defined).
module tb_clk_div_cascade;

   localparam int DIV_A    = 4;
   localparam int DIV_B    = 6;
   localparam int FAST_DIV = 2;
   localparam int SEC_W    = 3;

   logic clk;
   logic rst_n;
   logic en;
   logic sync_clr;
   logic fast;
   logic tick_a, tick_b, sq_a, sq_b;
`ifdef CLKDIV_SECCNT_EN
   logic [SEC_W-1:0] sec_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_sec  = 0;

   clk_div_cascade #(
      .DIV_A    (DIV_A),
      .DIV_B    (DIV_B),
      .FAST_DIV (FAST_DIV),
      .SEC_W    (SEC_W)
   ) dut (
      .in_50MHz (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync_clr (sync_clr),
      .fast     (fast),
      .tick_a   (tick_a),
      .tick_b   (tick_b),
      .sq_a     (sq_a),
`ifdef CLKDIV_SECCNT_EN
      .sq_b     (sq_b),
      .sec_cnt  (sec_cnt)
`else
      .sq_b     (sq_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic en;
      logic clr;
      logic fast;
      logic ta;
      logic tb;
      logic sa;
      logic sb;
   } vec_t;

   vec_t vecs[48];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string name, input logic ta, input logic tbb,
                             input logic sa, input logic sb);
      check({name, ".tick_a"}, 32'(tick_a), 32'(ta));
      check({name, ".tick_b"}, 32'(tick_b), 32'(tbb));
      check({name, ".sq_a"},   32'(sq_a),   32'(sa));
      check({name, ".sq_b"},   32'(sq_b),   32'(sb));
`ifdef CLKDIV_SECCNT_EN
      check({name, ".sec_cnt"}, 32'(sec_cnt), 32'(exp_sec % (1 << SEC_W)));
`endif
   endtask

   // One clock edge, then compare outputs 1 ns later; inputs are also changed at that point.
   task automatic edge_chk(input string name, input logic ta, input logic tbb,
                           input logic sa, input logic sb);
      @(posedge clk);
      #1;
      if (tbb) exp_sec++;
      check_outs(name, ta, tbb, sa, sb);
   endtask

   task automatic run_free(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Normal-mode pattern from reset: tick_a every 4 edges, tick_b every 24,
      // sq_a high for cnt_a in {2,3}, sq_b high while cnt_b in {3,4,5} (edges 12..23).
      for (int k = 1; k <= 48; k++) begin
         vecs[k-1].en   = 1'b1;
         vecs[k-1].clr  = 1'b0;
         vecs[k-1].fast = 1'b0;
         vecs[k-1].ta   = (k % 4 == 0);
         vecs[k-1].tb   = (k % 24 == 0);
         vecs[k-1].sa   = ((k % 4) >= 2);
         vecs[k-1].sb   = ((k % 24) >= 12);
      end

      rst_n    = 1'b0;
      en       = 1'b0;
      sync_clr = 1'b0;
      fast     = 1'b0;
      #2;
      check_outs("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outs("reset_held_edge", 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 48; i++) begin
         en       = vecs[i].en;
         sync_clr = vecs[i].clr;
         fast     = vecs[i].fast;
         edge_chk($sformatf("norm[%0d]", i + 1), vecs[i].ta, vecs[i].tb, vecs[i].sa, vecs[i].sb);
      end

      // cnt_a=0, cnt_b=0 here; two edges bring cnt_a to 2.
      edge_chk("pre_hold1", 1'b0, 1'b0, 1'b0, 1'b0);
      edge_chk("pre_hold2", 1'b0, 1'b0, 1'b1, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++)
         edge_chk($sformatf("hold[%0d]", i), 1'b0, 1'b0, 1'b1, 1'b0);
      en = 1'b1;
      edge_chk("resume1", 1'b0, 1'b0, 1'b1, 1'b0);
      edge_chk("resume2", 1'b1, 1'b0, 1'b0, 1'b0);

      // cnt_b=1; twelve edges bring cnt_b to 4 with cnt_a=0.
      for (int i = 1; i <= 12; i++)
         edge_chk($sformatf("to_b4[%0d]", i), (i % 4 == 0), 1'b0, ((i % 4) >= 2), (i >= 8));
      fast = 1'b1;
      // cnt_b=4 >= FAST_DIV-1 wraps on the next wrap_a, then tick_b every 8 cycles.
      for (int i = 1; i <= 16; i++)
         edge_chk($sformatf("fast[%0d]", i), (i % 4 == 0), (i % 8 == 4),
                  ((i % 4) >= 2), (i < 4) || ((i % 8) >= 4) ? (i < 4) : 1'b1);
      // After fast edge 16: cnt_b=1 (wrapped at 12), cnt_a=0. Four more to realign cnt_b=0.
      for (int i = 17; i <= 20; i++)
         edge_chk($sformatf("fast[%0d]", i), (i % 4 == 0), (i == 20), ((i % 4) >= 2),
                  (i != 20));
      fast = 1'b0;
      for (int i = 1; i <= 24; i++)
         edge_chk($sformatf("slow[%0d]", i), (i % 4 == 0), (i == 24), ((i % 4) >= 2),
                  (i >= 12 && i < 24));

      // cnt_b=0, cnt_a=0; 23 edges reach cnt_b=5, cnt_a=3.
      run_free(23);
      check_outs("pre_clr", 1'b0, 1'b0, 1'b1, 1'b1);
      sync_clr = 1'b1;
      edge_chk("clr_edge", 1'b0, 1'b0, 1'b0, 1'b0);
      exp_sec  = 0;
      sync_clr = 1'b0;
      for (int i = 1; i <= 24; i++) begin
         if (i == 24) exp_sec = 0;
         edge_chk($sformatf("post_clr[%0d]", i), (i % 4 == 0), (i == 24), ((i % 4) >= 2),
                  (i >= 12 && i < 24));
      end

      // cnt_a=0, cnt_b=0; 14 edges reach cnt_a=2, cnt_b=3 so both squares are high.
      run_free(14);
      check_outs("pre_rst", 1'b0, 1'b0, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
      exp_sec = 0;
      #1 rst_n = 1'b1;
      for (int i = 1; i <= 24; i++)
         edge_chk($sformatf("post_rst[%0d]", i), (i % 4 == 0), (i == 24), ((i % 4) >= 2),
                  (i >= 12 && i < 24));

`ifdef CLKDIV_SECCNT_EN
      // Eight more stage-B periods: sec_cnt walks 2..7 and wraps to 0 then 1.
      for (int p = 0; p < 8; p++)
         for (int i = 1; i <= 24; i++)
            edge_chk($sformatf("sec[%0d.%0d]", p, i), (i % 4 == 0), (i == 24),
                     ((i % 4) >= 2), (i >= 12 && i < 24));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_cascade.md
Name: clk_div_cascade

Overview:
- Parametrised two-stage clock divider, the next generation of the board's fixed 50 MHz to 1 Hz divider.
- Stage A divides the board clock into a fast tick and square wave (default 1 kHz, used for display scan). Stage B divides stage A into a slow tick and square wave (default 1 Hz, the timekeeping base).
- Adds enable, synchronous clear and a runtime "fast" mode (default 10 Hz) for time-setting.
- All outputs are synchronous to the single board clock; no derived clocks leave the block.

Parameters:
- DIV_A, 50000, stage A divide ratio in clock cycles; even, ≥2.
- DIV_B, 1000, stage B divide ratio in stage A periods (normal mode); even, ≥2.
- FAST_DIV, 100, stage B divide ratio while fast=1; even, ≥2, ≤DIV_B.
- SEC_W, 17, width of the optional tick_b event counter.
- Counter widths are localparams: clog2(DIV_A) for stage A and clog2(DIV_B) for stage B.

Ports:
- in_50MHz  in  1  board clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, both stages hold.
- sync_clr  in  1  synchronous clear; priority over en.
- fast  in  1  selects FAST_DIV instead of DIV_B for stage B.
- tick_a  out  1  one-cycle pulse, once per DIV_A cycles.
- tick_b  out  1  one-cycle pulse, once per stage B period; coincident with a tick_a.
- sq_a  out  1  50% square wave, period DIV_A cycles.
- sq_b  out  1  50% square wave, period limit_b × DIV_A cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): cnt_a=0, cnt_b=0, and tick_a, tick_b, sq_a, sq_b all 0. Outputs are 0 immediately, with no clock edge needed.
- Internal signals: wrap_a = en & (cnt_a == DIV_A-1); limit_b = fast ? FAST_DIV : DIV_B.
- Stage A, on each rising edge with en=1:
  - cnt_a increments; on wrap_a it returns to 0.
  - tick_a is registered: tick_a = wrap_a.
  - The first tick_a is high during the cycle after the DIV_A-th enabled edge.
- Stage B advances only on edges where wrap_a=1:
  - If cnt_b ≥ limit_b-1, cnt_b returns to 0 and tick_b=1.
  - Otherwise cnt_b increments and tick_b=0.
  - tick_b is 0 on every other edge.
- Square waves are registered and exactly equal to the counter state after each edge:
  - sq_a = (cnt_a ≥ DIV_A/2).
  - sq_b = (cnt_b ≥ limit_b/2).
  - Each is low for the first half of its period and high for the second half, so no cumulative phase drift.
- en=0: cnt_a and cnt_b hold; tick_a=tick_b=0 from the next edge; sq_a and sq_b hold.
- sync_clr=1: on the next edge, both counters, both ticks and both squares go to 0, regardless of en or fast.
- fast change mid-period:
  - Takes effect at the next edge; no resynchronisation of cnt_b.
  - If cnt_b ≥ FAST_DIV-1 at the switch to fast=1, stage B wraps (tick_b=1) on the next wrap_a.
  - sq_b may show one shortened half-period at the switch; this is accepted.
- Latency: tick_b and tick_a rise in the same cycle; tick_b never occurs without tick_a.
- No other outputs or state.

Optional Feature:
- Macro: CLKDIV_SECCNT_EN.
- Defined: adds output port sec_cnt [SEC_W-1:0].
  - Reset and sync_clr set it to 0.
  - Increments by 1 on each edge where tick_b is being set to 1.
  - Wraps from 2^SEC_W-1 to 0; holds while en=0.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Bench parameters: DIV_A=4, DIV_B=6, FAST_DIV=2.
- Reset release, en=1 -> tick_a high after enabled edges 4, 8, 12, …; tick_b first high after edge 24, then every 24; sq_a follows pattern 0,1,2,3 → 0,0,1,1; sq_b high from edge 12 to 24.
- en=0 for 5 cycles at cnt_a=2 -> no ticks; counters and squares hold; after en=1, next tick_a comes 2 edges later.
- fast=1 asserted with cnt_b=4 -> tick_b on the next tick_a, then every 8 cycles; fast=0 restores period 24.
- sync_clr=1 and en=1 together at cnt_a=3, cnt_b=5 -> after the edge all counters and outputs are 0, no tick; counting restarts from 0.
- rst_n pulsed low between edges mid-count -> all outputs 0 immediately; after release, first tick_a after 4 edges.
- Default parameters, en=1 -> tick_a period 50,000 cycles; tick_b period 50,000,000 cycles; sq_b 25,000,000 cycles low then 25,000,000 high.
- With CLKDIV_SECCNT_EN, SEC_W=3 -> sec_cnt steps 0…7, then wraps to 0 on the 8th tick_b.
